// File: rtl/pipeline_stage_reg_pkg.sv
// rtl/pipeline_stage_reg_pkg.sv - shared state encoding and defaults for pipeline_stage_reg
package pipeline_stage_reg_pkg;

  // Occupancy of the stage: nothing held, head only, head plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Opcode shown downstream while the stage presents a bubble.
  localparam int NOP_OP_DEFAULT = 0;

  // Width of the backpressure cycle counter.
  localparam int STALL_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_stage_reg_if.sv
// rtl/pipeline_stage_reg_if.sv - upstream/downstream handshake bundle of one stage boundary
interface pipeline_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 6,
  parameter int OP_W   = 6
) ();
  import pipeline_stage_reg_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  alu_in;
  logic [DATA_W-1:0]  mem_in;
  logic [DEST_W-1:0]  dest_in;
  logic [OP_W-1:0]    op_in;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  alu_out;
  logic [DATA_W-1:0]  mem_out;
  logic [DEST_W-1:0]  dest_out;
  logic [OP_W-1:0]    op_out;
  logic [STALL_W-1:0] stall_cnt;

  // Surrounding pipeline: feeds words in, drains words out.
  modport master (
    output flush, in_valid, alu_in, mem_in, dest_in, op_in, out_ready,
    input  in_ready, out_valid, alu_out, mem_out, dest_out, op_out, stall_cnt
  );

  // The stage register itself.
  modport slave (
    input  flush, in_valid, alu_in, mem_in, dest_in, op_in, out_ready,
    output in_ready, out_valid, alu_out, mem_out, dest_out, op_out, stall_cnt
  );

endinterface

// File: rtl/pipeline_stage_reg_stage_entry.sv
// rtl/pipeline_stage_reg_stage_entry.sv - payload register with load and clear
module stage_entry #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Clear wins over load so a squash never lets a new word slip in.
  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else if (load) begin
      data_d = d;
    end
  end

  // Payload storage, zeroed by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - valid/ready pipeline stage register with optional skid entry
module pipeline_stage_reg
  import pipeline_stage_reg_pkg::*;
#(
  parameter int              DATA_W = 32,
  parameter int              DEST_W = 6,
  parameter int              OP_W   = 6,
  parameter int              SKID   = 1,
  parameter logic [OP_W-1:0] NOP_OP = OP_W'(NOP_OP_DEFAULT)
) (
  input logic                 clock,
  input logic                 reset,
  pipeline_stage_reg_if.slave bus
);

  localparam int PAY_W    = 2 * DATA_W + DEST_W + OP_W;
  localparam bit HAS_SKID = (SKID != 0);

  stage_state_e       state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] head_pay;
  logic [PAY_W-1:0] skid_pay;
  logic [PAY_W-1:0] head_src;
  logic             head_load;
  logic             skid_load;
  logic             take_skid;
  logic             out_valid;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;

  assign in_pay    = {bus.alu_in, bus.mem_in, bus.dest_in, bus.op_in};
  assign out_valid = (state_q != ST_EMPTY);
  // With a skid entry, ready comes straight from a flop so out_ready never
  // reaches in_ready combinationally; without one, ready looks through.
  assign in_ready  = HAS_SKID ? in_ready_q : (!out_valid || bus.out_ready);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;
  assign head_src  = take_skid ? skid_pay : in_pay;

  // Occupancy transitions, entry load strobes, registered ready and stall count.
  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    skid_load = 1'b0;
    take_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_MAIN;
          head_load = 1'b1;
        end
      end
      ST_MAIN: begin
        if (in_fire && out_fire) begin
          head_load = 1'b1;
        end else if (in_fire && HAS_SKID) begin
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d   = ST_MAIN;
          head_load = 1'b1;
          take_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A squash discards everything, including a word accepted this cycle.
    if (bus.flush) begin
      state_d   = ST_EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
      take_skid = 1'b0;
    end
    in_ready_d  = (state_d != ST_FULL);
    stall_cnt_d = (out_valid && !bus.out_ready) ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // Control state; the stall counter survives flush and clears only on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  stage_entry #(.W(PAY_W)) u_head (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .load  (head_load),
    .d     (head_src),
    .q     (head_pay)
  );

  // Never loaded in single-entry mode, so it reduces to constant zero there.
  stage_entry #(.W(PAY_W)) u_skid (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .load  (skid_load && HAS_SKID),
    .d     (in_pay),
    .q     (skid_pay)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.stall_cnt = stall_cnt_q;
  // Data fields show the head as-is; control fields turn into a bubble when empty.
  assign bus.alu_out   = head_pay[PAY_W-1 -: DATA_W];
  assign bus.mem_out   = head_pay[PAY_W-DATA_W-1 -: DATA_W];
  assign bus.dest_out  = out_valid ? head_pay[OP_W +: DEST_W] : '0;
  assign bus.op_out    = out_valid ? head_pay[0 +: OP_W] : NOP_OP;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb/tb_pipeline_stage_reg.sv - self-checking bench for pipeline_stage_reg in both modes
module tb_pipeline_stage_reg;
  import pipeline_stage_reg_pkg::*;

  localparam int DW = 32;
  localparam int RW = 6;
  localparam int OW = 6;
  localparam logic [OW-1:0] NOP0 = 6'h00;
  localparam logic [OW-1:0] NOP1 = 6'h3F;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [RW-1:0] dest;
    logic [OW-1:0] op;
  } word_t;

  typedef struct {
    logic          ov;
    logic          ir;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [RW-1:0] dest;
    logic [OW-1:0] op;
    logic [15:0]   st;
  } obs_t;

  typedef struct {
    bit v;
    int w;
    bit o;
    bit eov;
    int ealu;
    bit eir;
    int est;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b1;

  bit    iv   [2];
  bit    ordy [2];
  bit    fl   [2];
  word_t iw   [2];

  word_t         mq       [2][$];
  logic [DW-1:0] last_alu [2];
  logic [DW-1:0] last_mem [2];
  int unsigned   mstall   [2];
  vec_t          tab      [2][10];
  obs_t          o;

  pipeline_stage_reg_if #(.DATA_W(DW), .DEST_W(RW), .OP_W(OW)) bus0 ();
  pipeline_stage_reg_if #(.DATA_W(DW), .DEST_W(RW), .OP_W(OW)) bus1 ();

  assign bus0.flush = fl[0];       assign bus1.flush = fl[1];
  assign bus0.in_valid = iv[0];    assign bus1.in_valid = iv[1];
  assign bus0.out_ready = ordy[0]; assign bus1.out_ready = ordy[1];
  assign bus0.alu_in = iw[0].alu;  assign bus1.alu_in = iw[1].alu;
  assign bus0.mem_in = iw[0].mem;  assign bus1.mem_in = iw[1].mem;
  assign bus0.dest_in = iw[0].dest; assign bus1.dest_in = iw[1].dest;
  assign bus0.op_in = iw[0].op;    assign bus1.op_in = iw[1].op;

  pipeline_stage_reg #(.DATA_W(DW), .DEST_W(RW), .OP_W(OW), .SKID(0)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0)
  );
  pipeline_stage_reg #(.DATA_W(DW), .DEST_W(RW), .OP_W(OW), .SKID(1), .NOP_OP(NOP1)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1)
  );

  function automatic logic [OW-1:0] nop_of(int d);
    return (d == 1) ? NOP1 : NOP0;
  endfunction

  function automatic word_t mkw(logic [31:0] w);
    word_t r;
    r.alu  = w;
    r.mem  = w << 4;
    r.dest = RW'(w);
    r.op   = OW'(w + 32'd16);
    return r;
  endfunction

  // Capacity two with registered ready, or capacity one with look-through ready.
  function automatic bit exp_ir(int d);
    if (d == 1) return (mq[1].size() < 2);
    return (mq[0].size() == 0) || ordy[0];
  endfunction

  function automatic obs_t observe(int d);
    obs_t r;
    if (d == 0) begin
      r.ov = bus0.out_valid; r.ir = bus0.in_ready; r.alu = bus0.alu_out; r.mem = bus0.mem_out;
      r.dest = bus0.dest_out; r.op = bus0.op_out; r.st = bus0.stall_cnt;
    end else begin
      r.ov = bus1.out_valid; r.ir = bus1.in_ready; r.alu = bus1.alu_out; r.mem = bus1.mem_out;
      r.dest = bus1.dest_out; r.op = bus1.op_out; r.st = bus1.stall_cnt;
    end
    return r;
  endfunction

  task automatic chk(int d, string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s actual=%h expected=%h t=%0t", d, nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(int d);
    mq[d].delete();
    last_alu[d] = '0;
    last_mem[d] = '0;
    mstall[d]   = 0;
  endtask

  task automatic model_step(int d);
    bit ov;
    bit ir;
    ov = (mq[d].size() > 0);
    ir = exp_ir(d);
    if (ov && !ordy[d] && mstall[d] < 32'd65535) mstall[d]++;
    if (fl[d]) begin
      mq[d].delete();
      last_alu[d] = '0;
      last_mem[d] = '0;
    end else begin
      if (ov && ordy[d]) void'(mq[d].pop_front());
      if (iv[d] && ir) mq[d].push_back(iw[d]);
    end
    if (mq[d].size() > 0) begin
      last_alu[d] = mq[d][0].alu;
      last_mem[d] = mq[d][0].mem;
    end
  endtask

  task automatic check_dut(int d);
    obs_t r;
    word_t h;
    r = observe(d);
    chk(d, "out_valid", 32'(r.ov), 32'(mq[d].size() > 0));
    chk(d, "in_ready", 32'(r.ir), 32'(exp_ir(d)));
    chk(d, "stall_cnt", 32'(r.st), mstall[d]);
    if (mq[d].size() > 0) begin
      h = mq[d][0];
      chk(d, "alu_out", r.alu, h.alu);
      chk(d, "mem_out", r.mem, h.mem);
      chk(d, "dest_out", 32'(r.dest), 32'(h.dest));
      chk(d, "op_out", 32'(r.op), 32'(h.op));
    end else begin
      chk(d, "bubble alu_out", r.alu, last_alu[d]);
      chk(d, "bubble mem_out", r.mem, last_mem[d]);
      chk(d, "bubble dest_out", 32'(r.dest), 32'd0);
      chk(d, "bubble op_out", 32'(r.op), 32'(nop_of(d)));
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; fl[d] = 1'b0; iw[d] = '0;
    end
  endtask

  task automatic sample();
    @(negedge clock);
    if (chk_on) begin
      for (int d = 0; d < 2; d++) check_dut(d);
    end
  endtask

  task automatic advance();
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (!reset) model_reset(d);
      else model_step(d);
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic set_row(int d, int r, int v, int w, int ord, int eov, int ealu, int eir, int est);
    tab[d][r].v = (v != 0);   tab[d][r].w = w;       tab[d][r].o = (ord != 0);
    tab[d][r].eov = (eov != 0); tab[d][r].ealu = ealu; tab[d][r].eir = (eir != 0);
    tab[d][r].est = est;
  endtask

  task automatic check_reset_values(string tag);
    for (int d = 0; d < 2; d++) begin
      o = observe(d);
      chk(d, {tag, " out_valid"}, 32'(o.ov), 32'd0);
      chk(d, {tag, " in_ready"}, 32'(o.ir), 32'd1);
      chk(d, {tag, " alu_out"}, o.alu, 32'd0);
      chk(d, {tag, " mem_out"}, o.mem, 32'd0);
      chk(d, {tag, " dest_out"}, 32'(o.dest), 32'd0);
      chk(d, {tag, " op_out"}, 32'(o.op), 32'(nop_of(d)));
      chk(d, {tag, " stall_cnt"}, 32'(o.st), 32'd0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_all();
    model_reset(0);
    model_reset(1);

    // Words 1..4 with out_ready low for rows 2..5; upstream holds each word until accepted.
    //            d  r  v  w  o  ov alu ir st
    set_row(1, 0, 1, 1, 1, 0, 0, 1, 0);
    set_row(1, 1, 1, 2, 1, 1, 1, 1, 0);
    set_row(1, 2, 1, 3, 0, 1, 2, 1, 0);
    set_row(1, 3, 1, 4, 0, 1, 2, 0, 1);
    set_row(1, 4, 1, 4, 0, 1, 2, 0, 2);
    set_row(1, 5, 1, 4, 0, 1, 2, 0, 3);
    set_row(1, 6, 1, 4, 1, 1, 2, 0, 4);
    set_row(1, 7, 1, 4, 1, 1, 3, 1, 4);
    set_row(1, 8, 0, 0, 1, 1, 4, 1, 4);
    set_row(1, 9, 0, 0, 1, 0, 4, 1, 4);
    set_row(0, 0, 1, 1, 1, 0, 0, 1, 0);
    set_row(0, 1, 1, 2, 1, 1, 1, 1, 0);
    set_row(0, 2, 1, 3, 0, 1, 2, 0, 0);
    set_row(0, 3, 1, 3, 0, 1, 2, 0, 1);
    set_row(0, 4, 1, 3, 0, 1, 2, 0, 2);
    set_row(0, 5, 1, 3, 0, 1, 2, 0, 3);
    set_row(0, 6, 1, 3, 1, 1, 2, 1, 4);
    set_row(0, 7, 1, 4, 1, 1, 3, 1, 4);
    set_row(0, 8, 0, 0, 1, 1, 4, 1, 4);
    set_row(0, 9, 0, 0, 1, 0, 4, 1, 4);

    // Reset state.
    do_reset();
    sample();
    check_reset_values("reset");
    advance();

    // Single word, one-cycle latency.
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b1;
      iw[d] = '{alu: 32'h1234_5678, mem: 32'h0, dest: 6'd5, op: 6'h23};
      ordy[d] = 1'b1;
    end
    cycle();
    for (int d = 0; d < 2; d++) iv[d] = 1'b0;
    sample();
    for (int d = 0; d < 2; d++) begin
      o = observe(d);
      chk(d, "first out_valid", 32'(o.ov), 32'd1);
      chk(d, "first alu_out", o.alu, 32'h1234_5678);
      chk(d, "first op_out", 32'(o.op), 32'h23);
      chk(d, "first dest_out", 32'(o.dest), 32'd5);
    end
    advance();

    // Backpressure stream table, one mode at a time.
    for (int d = 0; d < 2; d++) begin
      idle_all();
      do_reset();
      for (int r = 0; r < 10; r++) begin
        idle_all();
        iv[d]   = tab[d][r].v;
        iw[d]   = mkw(32'(tab[d][r].w));
        ordy[d] = tab[d][r].o;
        sample();
        o = observe(d);
        chk(d, $sformatf("tab%0d out_valid", r), 32'(o.ov), 32'(tab[d][r].eov));
        chk(d, $sformatf("tab%0d alu_out", r), o.alu, 32'(tab[d][r].ealu));
        chk(d, $sformatf("tab%0d in_ready", r), 32'(o.ir), 32'(tab[d][r].eir));
        chk(d, $sformatf("tab%0d stall_cnt", r), 32'(o.st), 32'(tab[d][r].est));
        advance();
      end
    end

    // Flush a full stage together with an incoming word.
    idle_all();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = 1'b1; iw[d] = mkw(32'hA0 + 32'(k)); ordy[d] = 1'b0;
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      fl[d] = 1'b1; iv[d] = 1'b1; iw[d] = mkw(32'hDEAD); ordy[d] = 1'b0;
    end
    sample();
    o = observe(1);
    chk(1, "full before flush in_ready", 32'(o.ir), 32'd0);
    advance();
    idle_all();
    sample();
    for (int d = 0; d < 2; d++) begin
      o = observe(d);
      chk(d, "flush out_valid", 32'(o.ov), 32'd0);
      chk(d, "flush op_out", 32'(o.op), 32'(nop_of(d)));
      chk(d, "flush dest_out", 32'(o.dest), 32'd0);
      chk(d, "flush alu_out", o.alu, 32'd0);
      chk(d, "flush in_ready", 32'(o.ir), 32'd1);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
      for (int d = 0; d < 2; d++) begin
        o = observe(d);
        chk(d, "post-flush no word", 32'(o.ov), 32'd0);
      end
      advance();
    end

    // Randomized traffic with occasional flush, both modes against the queue model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit    v;
      bit    rd;
      bit    f;
      word_t w;
      v  = ($urandom_range(0, 99) < 70);
      rd = ($urandom_range(0, 99) < 65);
      f  = ($urandom_range(0, 63) == 0);
      w.alu  = $urandom();
      w.mem  = $urandom();
      w.dest = RW'($urandom());
      w.op   = OW'($urandom());
      for (int d = 0; d < 2; d++) begin
        iv[d] = v; ordy[d] = rd; fl[d] = f; iw[d] = w;
      end
      cycle();
    end

    // Asynchronous reset while full.
    idle_all();
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = 1'b1; iw[d] = mkw(32'h55 + 32'(k)); ordy[d] = 1'b0;
      end
      cycle();
    end
    sample();
    o = observe(1);
    chk(1, "full before reset in_ready", 32'(o.ir), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async reset");
    model_reset(0);
    model_reset(1);
    advance();
    idle_all();
    cycle();
    reset = 1'b1;

    // Long stall: counter saturates and holds.
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b1; iw[d] = mkw(32'h77); ordy[d] = 1'b0;
    end
    cycle();
    for (int d = 0; d < 2; d++) iv[d] = 1'b0;
    for (int n = 0; n < 70000; n++) begin
      chk_on = ((n % 8192) == 0) || (n >= 69995);
      cycle();
    end
    chk_on = 1'b1;
    sample();
    for (int d = 0; d < 2; d++) begin
      o = observe(d);
      chk(d, "saturated stall_cnt", 32'(o.st), 32'h0000_FFFF);
      chk(d, "stalled out_valid", 32'(o.ov), 32'd1);
    end
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Parametrised pipeline stage register for the MIPS datapath. Carries the ALU result, memory data, destination register and opcode between stages, adding valid/ready flow control, stall and flush support, bubble insertion, and an optional skid entry for full throughput under backpressure. It replaces the fixed always-load inter-stage registers. One instance goes at each stage boundary (EX/MEM, MEM/WB).

## Interface
- `DATA_W`, 32: width of `alu_*` and `mem_*` payloads
- `DEST_W`, 6: width of `dest_*`
- `OP_W`, 6: width of `op_*`
- `SKID`, 1: 1 = two-entry skid stage with registered `in_ready`; 0 = single entry with combinational `in_ready`
- `NOP_OP`, 0: opcode driven on `op_out` while no valid entry is presented
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  upstream presents a word
- `in_ready`  out  1  stage accepts the word this cycle
- `alu_in`, `mem_in`  in  DATA_W  payload
- `dest_in`  in  DEST_W  payload
- `op_in`  in  OP_W  payload
- `out_valid`  out  1  word presented downstream
- `out_ready`  in  1  downstream accepts
- `alu_out`, `mem_out`  out  DATA_W  head payload
- `dest_out`  out  DEST_W  head payload
- `op_out`  out  OP_W  head payload
- `stall_cnt`  out  16  saturating count of cycles with `out_valid && !out_ready`

## Operation
- A transfer occurs on the rising edge when `valid && ready` on that side.
- States for `SKID=1`:
  - EMPTY: `out_valid` = 0, `in_ready` = 1.
  - MAIN: head valid, `in_ready` = 1.
  - FULL: head and skid entries valid, `in_ready` = 0.
- Transitions:
  - EMPTY → MAIN on input transfer.
  - MAIN with input only → FULL, captured into skid.
  - MAIN with input and output → MAIN, head reloaded.
  - MAIN with output only → EMPTY.
  - FULL on output → MAIN, skid moves to head.
- `in_ready` in `SKID=1` is a register output: `in_ready` = !FULL in the next state.
- `SKID=0` states: EMPTY and MAIN only. `in_ready` = `!out_valid || out_ready` (combinational).
- FIFO order is strict. No word is lost or duplicated.
- Bubble rule: when `out_valid` = 0, `op_out` = `NOP_OP` and `dest_out` = 0. `alu_out` and `mem_out` keep their last value, except after reset or flush, when they are 0.
- `flush` overrides everything:
  - Next state is EMPTY and all payload registers are cleared.
  - An input transfer in the flush cycle is discarded; upstream treats it as consumed.
  - `in_ready` returns to 1 on the next cycle.
- `stall_cnt` increments once per stalled cycle and saturates at 16'hFFFF. It clears only on reset, not on flush.

## Timing
- Latency: 1 cycle from input transfer to `out_valid` on an empty stage.
- Throughput: 1 word/cycle while `out_ready` = 1, in both modes.
- `SKID=1` has no combinational path from `out_ready` to `in_ready`. After `out_ready` drops, one further word is absorbed into the skid entry.
- Reset (asynchronous assert, synchronous release):
  - `out_valid` = 0, `in_ready` = 1.
  - Payload outputs 0, with `op_out` = `NOP_OP`.
  - `stall_cnt` = 0.
- Reset asserted mid-transfer drops both entries immediately.

## Structure
- Shared package: state encoding constants (EMPTY/MAIN/FULL) and the default `NOP_OP` value.
- One sub-module, `stage_entry`: a width-parametrised payload register with load and clear inputs, instantiated for head and skid.
- The top level holds the FSM, ready/valid logic, bubble muxing and `stall_cnt`.

## Test plan
- Reset, then `in_valid` with `alu_in`=32'h1234_5678, `op_in`=6'h23, `dest_in`=5, `out_ready`=1 → next cycle `out_valid`=1, `alu_out`=32'h1234_5678, `op_out`=6'h23, `dest_out`=5.
- `SKID=1`, stream words 1,2,3,4 with `out_ready` low from cycle 2 to cycle 5 → word 2 held at head, word 3 in skid, `in_ready`=0 the cycle after. After release the outputs are 1,2,3,4 in order with no loss; `stall_cnt`=4.
- `SKID=0`, same stimulus → `in_ready` falls in the same cycle as `out_ready`; order 1,2,3,4 preserved.
- FULL stage, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `op_out`=`NOP_OP`, `dest_out`=0, `alu_out`=0, `in_ready`=1; the flushed input word never appears.
- Hold `out_valid`=1 with `out_ready`=0 for 70000 cycles → `stall_cnt` = 16'hFFFF and stays there.
- Assert `reset` low mid-stream while FULL → outputs go to reset values immediately, without waiting for a clock edge.
